// File: rtl/router_sta.sv
// rtl/router_sta.sv - registered XY route-compute unit for a 2x4 mesh router input stage
module router_sta #(
  parameter int PORTS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] router_add,
  input  logic [2:0] dst,
  output logic [2:0] port
);

  localparam logic [2:0] DIR_LOCAL = 3'd0;
  localparam logic [2:0] DIR_EAST  = 3'd1;
  localparam logic [2:0] DIR_WEST  = 3'd2;
  localparam logic [2:0] DIR_VERT  = 3'd3;
  localparam logic [2:0] DIR_ERROR = 3'd7;

  // Corner routers own 3 ports, middle routers own 4; anything else never matches a column.
  localparam bit IS_CORNER_VARIANT = (PORTS == 3);
  localparam bit IS_MIDDLE_VARIANT = (PORTS == 4);

  logic [1:0] sx;
  logic [1:0] dx;
  logic       sy;
  logic       dy;
  logic       corner_col;
  logic       placement_ok;
  logic [2:0] route_dir;
  logic [2:0] port_d;
  logic [2:0] port_q;

  assign sx = router_add[1:0];
  assign sy = router_add[2];
  assign dx = dst[1:0];
  assign dy = dst[2];

  // Placement check: the variant must sit in a column that matches its port count.
  always_comb begin
    corner_col   = (sx == 2'd0) || (sx == 2'd3);
    placement_ok = 1'b0;
    if (IS_CORNER_VARIANT) begin
      placement_ok = corner_col;
    end else if (IS_MIDDLE_VARIANT) begin
      placement_ok = !corner_col;
    end
  end

  // Dimension-ordered route: resolve X first, then switch rows, else deliver locally.
  always_comb begin
    route_dir = DIR_LOCAL;
    if (dx > sx) begin
      route_dir = DIR_EAST;
    end else if (dx < sx) begin
      route_dir = DIR_WEST;
    end else if (dy != sy) begin
      route_dir = DIR_VERT;
    end
  end

  // Next output: hold unless enabled; misplaced instances report ERROR for every destination.
  always_comb begin
    port_d = port_q;
    if (en) begin
      port_d = placement_ok ? route_dir : DIR_ERROR;
    end
  end

  // Output register; rst_n is an active-high synchronous reset that overrides en.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      port_q <= DIR_LOCAL;
    end else begin
      port_q <= port_d;
    end
  end

  assign port = port_q;

endmodule

// File: tb/tb_router_sta.sv
// tb/tb_router_sta.sv - randomized self-checking bench for both router_sta variants
module tb_router_sta;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] router_add;
  logic [2:0] dst;
  logic [2:0] port3;
  logic [2:0] port4;

  int n_checks;
  int n_fail;

  router_sta #(.PORTS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .router_add(router_add), .dst(dst), .port(port3)
  );

  router_sta #(.PORTS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .router_add(router_add), .dst(dst), .port(port4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic on the mesh coordinates.
  function automatic int ref_route(input int ports, input int ra, input int d);
    int sx, sy, dxv, dyv;
    bit corner, legal;
    sx = ra % 4;
    sy = ra / 4;
    dxv = d % 4;
    dyv = d / 4;
    corner = (sx == 0) || (sx == 3);
    if (ports == 3) legal = corner;
    else if (ports == 4) legal = !corner;
    else legal = 0;
    if (!legal) return 7;
    if (dxv > sx) return 1;
    if (dxv < sx) return 2;
    if (dyv != sy) return 3;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b1; router_add = 3'b000; dst = 3'b111;
    step();
    step();
    n_checks++;
    if (port3 !== 3'd0) begin n_fail++; $display("FAIL reset_p3 got %0d expected 0", port3); end
    n_checks++;
    if (port4 !== 3'd0) begin n_fail++; $display("FAIL reset_p4 got %0d expected 0", port4); end
    rst_n = 1'b0;
    step();
    n_checks++;
    if (port3 !== 3'd1) begin n_fail++; $display("FAIL reset_release_p3 got %0d expected 1", port3); end
    n_checks++;
    if (port4 !== 3'd7) begin n_fail++; $display("FAIL reset_release_p4 got %0d expected 7", port4); end
  endtask

  task automatic test_enable_hold();
    router_add = 3'b000; dst = 3'b001; en = 1'b1;
    step();
    n_checks++;
    if (port3 !== 3'd1) begin n_fail++; $display("FAIL hold_first got %0d expected 1", port3); end
    en = 1'b0; dst = 3'b100;
    step();
    step();
    n_checks++;
    if (port3 !== 3'd1) begin n_fail++; $display("FAIL hold_keep got %0d expected 1", port3); end
    en = 1'b1;
    step();
    n_checks++;
    if (port3 !== 3'd3) begin n_fail++; $display("FAIL hold_resume got %0d expected 3", port3); end
  endtask

  task automatic test_corner_exhaustive();
    int exp_tab[8];
    exp_tab = '{2, 2, 2, 0, 2, 2, 2, 3};
    en = 1'b1; router_add = 3'b011;
    for (int d = 0; d < 8; d++) begin
      dst = 3'(d);
      step();
      n_checks++;
      if (port3 !== 3'(exp_tab[d]))
        begin n_fail++; $display("FAIL corner_dst%0d got %0d expected %0d", d, port3, exp_tab[d]); end
    end
  endtask

  task automatic test_middle_exhaustive();
    int exp_tab[8];
    exp_tab = '{2, 3, 1, 1, 2, 0, 1, 1};
    en = 1'b1; router_add = 3'b101;
    for (int d = 0; d < 8; d++) begin
      dst = 3'(d);
      step();
      n_checks++;
      if (port4 !== 3'(exp_tab[d]))
        begin n_fail++; $display("FAIL middle_dst%0d got %0d expected %0d", d, port4, exp_tab[d]); end
    end
  endtask

  task automatic test_placement();
    en = 1'b1; router_add = 3'b001;
    for (int d = 0; d < 8; d++) begin
      dst = 3'(d);
      step();
      n_checks++;
      if (port3 !== 3'd7) begin n_fail++; $display("FAIL place3_dst%0d got %0d expected 7", d, port3); end
    end
    router_add = 3'b100;
    for (int d = 0; d < 8; d++) begin
      dst = 3'(d);
      step();
      n_checks++;
      if (port4 !== 3'd7) begin n_fail++; $display("FAIL place4_dst%0d got %0d expected 7", d, port4); end
    end
    router_add = 3'b110; dst = 3'b110;
    step();
    n_checks++;
    if (port4 !== 3'd0) begin n_fail++; $display("FAIL place4_legal got %0d expected 0", port4); end
  endtask

  task automatic test_full_sweep();
    int e3, e4;
    int pairs[$];
    rst_n = 1'b0; en = 1'b1;
    for (int p = 0; p < 64; p++) pairs.push_back(p);
    pairs.shuffle();
    // Exhaustive pass in shuffled order, then a random pass with random enable and resets.
    e3 = 0; e4 = 0;
    for (int i = 0; i < 64 + 400; i++) begin
      int p;
      int gap;
      if (i < 64) begin
        p = pairs[i];
        en = 1'b1;
        rst_n = 1'b0;
      end else begin
        p = int'($urandom_range(0, 63));
        en = ($urandom_range(0, 3) != 0);
        rst_n = ($urandom_range(0, 15) == 0);
      end
      router_add = 3'(p / 8);
      dst = 3'(p % 8);
      if (rst_n) begin
        e3 = 0; e4 = 0;
      end else if (en) begin
        e3 = ref_route(3, p / 8, p % 8);
        e4 = ref_route(4, p / 8, p % 8);
      end
      step();
      n_checks++;
      if (port3 !== 3'(e3))
        begin n_fail++; $display("FAIL sweep3 ra=%0d dst=%0d got %0d expected %0d", p / 8, p % 8, port3, e3); end
      n_checks++;
      if (port4 !== 3'(e4))
        begin n_fail++; $display("FAIL sweep4 ra=%0d dst=%0d got %0d expected %0d", p / 8, p % 8, port4, e4); end
      n_checks++;
      if ((port3 >= 3'd4 && port3 <= 3'd6) || (port4 >= 3'd4 && port4 <= 3'd6))
        begin n_fail++; $display("FAIL sweep_reserved_code got %0d/%0d expected none of 4..6", port3, port4); end
      // Wiggle inputs mid-cycle sometimes; only the next edge sample may matter.
      gap = int'($urandom_range(0, 1));
      if (gap != 0) begin
        router_add = 3'($urandom_range(0, 7));
        dst = 3'($urandom_range(0, 7));
        #2;
        router_add = 3'(p / 8);
        dst = 3'(p % 8);
      end
    end
    rst_n = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b1; en = 1'b0; router_add = 3'd0; dst = 3'd0;
    test_reset();
    test_enable_hold();
    test_corner_exhaustive();
    test_middle_exhaustive();
    test_placement();
    test_full_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_sta.md
Name: router_sta

Overview:
- Static XY route-compute unit for the 2x4 mesh NoC of 8 routers with 3-bit addresses.
- Given the router's own address and a packet destination address, produces a registered output-direction code.
- One block, parameterised by router port count:
  - PORTS=3 is the corner-router variant (router_sta_3port instance role).
  - PORTS=4 is the middle-router variant (router_sta_4port instance role).
- Sits in each router's input stage, feeding the switch allocator.

Parameters:
- PORTS, 3, number of router ports: 3 = corner router (local + 2 neighbours), 4 = middle router (local + 3 neighbours); other values illegal.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock, reset is synchronous and active-high (asserted when rst_n=1).
- en  input  1  compute enable; port updates only when en=1.
- router_add  input  3  this router's address: bit2 = row Y (0..1), bits[1:0] = column X (0..3).
- dst  input  3  destination address, same encoding.
- port  output  3  registered direction code: 3'd0 LOCAL, 3'd1 EAST (X+1), 3'd2 WEST (X-1), 3'd3 VERT (other row), 3'd7 ERROR.

Behaviour:
- Reset: on the rising edge with rst_n=1, port <= 3'd0 (LOCAL). Reset has priority over en.
- Reset mid-operation clears port on that edge.
- Registered output, 1-cycle latency: on the rising edge with reset inactive and en=1, port <= f(router_add, dst) sampled at that edge.
- With en=0 and reset inactive, port holds its value.
- Route function f (dimension-ordered, X first):
  - Let sx = router_add[1:0], sy = router_add[2], dx = dst[1:0], dy = dst[2].
  - dx > sx -> EAST (3'd1).
  - dx < sx -> WEST (3'd2).
  - dx == sx and dy != sy -> VERT (3'd3).
  - dx == sx and dy == sy -> LOCAL (3'd0).
  - X comparison is unsigned 2-bit; no wrap-around (mesh, not torus).
- Placement check, applied before the route function:
  - PORTS=3 is legal only at corner columns (sx==0 or sx==3).
  - PORTS=4 is legal only at middle columns (sx==1 or sx==2).
  - Illegal placement -> port <= 3'd7 (ERROR) for every dst while en=1.
- By construction, XY never selects a non-existent neighbour: sx==0 never yields WEST, and sx==3 never yields EAST.
- Codes 3'd4..3'd6 are never produced.
- No combinational path from inputs to port.
- Inputs changing between edges have no effect until the next enabled edge.

Test Plan:
- Reset: rst_n=1 for 2 cycles with en=1, router_add=3'b000, dst=3'b111 -> port=3'd0. After rst_n=0, the next edge gives port=3'd1 (EAST).
- Enable hold: PORTS=3, router_add=3'b000, dst=3'b001, en=1 -> port=3'd1. Drop en, change dst to 3'b100 -> port stays 3'd1. Raise en -> 3'd3 one cycle later.
- Corner exhaustive: PORTS=3, router_add=3'b011, sweep dst 0..7 -> WEST,WEST,WEST,LOCAL,WEST,WEST,WEST,VERT (2,2,2,0,2,2,2,3), each one cycle after the dst change.
- Middle exhaustive: PORTS=4, router_add=3'b101, sweep dst 0..7 -> 2,3,1,1,2,0,1,1.
- Placement errors: PORTS=3 with router_add=3'b001 and any dst -> 3'd7. PORTS=4 with router_add=3'b100 -> 3'd7. PORTS=4 with router_add=3'b110, dst=3'b110 -> 3'd0.
- Full sweep: both variants, router_add 0..7 x dst 0..7 at one change per 10-20 ns. Compare against the reference model with 1-cycle latency; check codes 4..6 never appear.
